sub_bytes_seq: RTL and testbench
================================

Name: sub_bytes_seq

Overview:
Iterative SubBytes stage for the AES datapath. Takes a 128-bit AES state, passes every byte through the existing `sbox` lookup, and returns the substituted state. It uses LANES sbox instances, so it trades area for latency. It sits between AddRoundKey and ShiftRows in the round datapath, with valid/ready handshakes on both sides.

Parameters:
LANES, 1, number of sbox instances, i.e. bytes substituted per cycle; legal values 1, 2, 4, 8, 16.
N_STEPS, 16/LANES, derived (localparam), number of BUSY cycles per block.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  upstream presents a state on in_data.
in_ready  output  1  block can accept a state.
in_data  input  128  AES state; byte k = in_data[127-8k -: 8], so byte 0 is the MSB byte.
out_valid  output  1  out_data holds a completed substituted state.
out_ready  input  1  downstream accepts out_data.
out_data  output  128  substituted state, same byte order as in_data.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE, step counter=0, working register=0.
  - Outputs: in_ready=1, out_valid=0, out_data=128'h0.
  - Reset mid-operation discards the partial block; no output is produced for it.
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: load the working register with in_data, clear the counter, go to BUSY.
  - On an edge with in_valid=0: stay in IDLE.
- BUSY:
  - in_ready=0; in_valid is ignored.
  - Each edge replaces bytes [cnt*LANES .. cnt*LANES+LANES-1] of the working register with their sbox images and increments cnt.
  - The edge that processes step N_STEPS-1 moves to DONE.
  - Processing order is byte 0 upward, so unprocessed bytes are always unmodified input bytes.
- DONE:
  - out_valid=1, in_ready=0, out_data = working register.
  - out_data is held stable while out_valid=1 and out_ready=0 (backpressure of any length).
  - On an edge with out_ready=1: go to IDLE and drop out_valid.
  - A new block is not accepted on that same edge; in_ready rises the following cycle.
- Latency: out_valid is visible N_STEPS cycles after the accepting edge (16 for LANES=1, 1 for LANES=16).
- Throughput: one block per N_STEPS+2 cycles with out_ready held high.
- out_data outside DONE is undefined for consumers. The implementation drives the working register, so out_data equals 0 after reset.
- The sbox instances are purely combinational; the only sequential elements are the FSM, counter and working register.
- Counter width is clog2(N_STEPS) with a minimum of 1 bit. The counter never wraps in use: it is cleared on acceptance and exits BUSY at N_STEPS-1.
- out_ready asserted in IDLE or BUSY has no effect.
- in_valid and out_ready asserted together in DONE: out_ready is honoured, in_valid is ignored.

Decomposition:
- Shared definitions include (aes_defs.vh):
  - AES_BLOCK_W=128, AES_BYTE_W=8, AES_NUM_BYTES=16.
  - FSM state encodings IDLE=2'd0, BUSY=2'd1, DONE=2'd2; these are also used by sibling round stages.
- Sub-module: the existing `sbox`, instantiated LANES times in a generate loop.
  - Lane j input = working byte cnt*LANES+j; its output is written back to the same position.
- No further sub-modules.

Test Plan:
1. LANES=1, in_data=000102030405060708090a0b0c0d0e0f, out_ready=1 → out_data=637c777bf26b6fc53001672bfed7ab76, out_valid asserted exactly 16 cycles after acceptance and lasting 1 cycle.
2. FIPS-197 round-1 vector, LANES=1 and LANES=16: in_data=193de3bea0f4e22b9ac68d2ae9f84808 → out_data=d42711aee0bf98f1b8b45de51e415230; latencies 16 and 1 respectively.
3. Backpressure: in_data=0, out_ready=0 for 10 cycles after out_valid → out_data stays 6363…63 (16×63) and out_valid stays 1; in_ready stays 0; in_valid pulses during BUSY/DONE are ignored. Raising out_ready → IDLE next cycle.
4. Reset mid-operation: accept ffff…ff (LANES=1), assert rst at step 7 → next cycle in_ready=1, out_valid=0, out_data=0. A following block 5252…52 yields 0000…00 with full 16-cycle latency.
5. Back-to-back: in_valid held high with alternating vectors (00…00, 0f…0f), out_ready=1 → outputs 63…63 then 76…76; in_valid is accepted every 18 cycles for LANES=1; no block is dropped or duplicated.
6. LANES=4, in_data=c0c1…cf (bytes 0xc0–0xcf) → out_data=ba78252e1ca6b4c6e8dd741f4bbd8b8a after 4 cycles.

Source files
------------

// File: rtl/sub_bytes_seq_pkg.sv
// Shared AES round-stage definitions: block geometry, FSM encoding and the
// forward S-box table with its lookup helper.
package sub_bytes_seq_pkg;

   localparam int unsigned AES_BLOCK_W   = 128;
   localparam int unsigned AES_BYTE_W    = 8;
   localparam int unsigned AES_NUM_BYTES = 16;

   // Encoding shared with the sibling round stages.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } fsm_state_t;

   // Forward S-box, entry 0 in the most significant byte.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Entry v sits at bit offset (255 - v) * 8, and ~v equals 255 - v.
   function automatic logic [AES_BYTE_W-1:0] sbox_lookup(input logic [AES_BYTE_W-1:0] value);
      return SBOX_TABLE[{~value, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/sub_bytes_seq_sbox.sv
// Purely combinational AES forward S-box, one byte in, one byte out.
module sbox
   import sub_bytes_seq_pkg::*;
(
   input  logic [AES_BYTE_W-1:0] byte_val,
   output logic [AES_BYTE_W-1:0] sub_val
);

   // Table lookup of the substituted byte.
   always_comb begin
      sub_val = sbox_lookup(byte_val);
   end

endmodule

// File: rtl/sub_bytes_seq.sv
// Iterative SubBytes stage: substitutes LANES bytes of the AES state per
// cycle, walking from byte 0 (MSB byte) upward, with valid/ready on both sides.
module sub_bytes_seq
   import sub_bytes_seq_pkg::*;
#(
   parameter int unsigned LANES = 1
)
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [AES_BLOCK_W-1:0] in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [AES_BLOCK_W-1:0] out_data
);

   localparam int unsigned N_STEPS = AES_NUM_BYTES / LANES;
   localparam int unsigned CNT_W   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_STEPS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   // Truncates to zero for LANES=16, where the counter only ever holds 0.
   localparam logic [3:0] LANES_4B = 4'(LANES);

   fsm_state_t             state_r;
   fsm_state_t             state_next_s;
   logic [CNT_W-1:0]       cnt_r;
   logic [CNT_W-1:0]       cnt_next_s;
   logic [AES_BLOCK_W-1:0] work_r;
   logic [AES_BLOCK_W-1:0] work_next_s;
   logic [AES_BLOCK_W-1:0] sub_state_s;
   logic                   in_ready_r;
   logic                   out_valid_r;

   logic [3:0]             base_s;
   logic [AES_BYTE_W-1:0]  work_bytes_s [AES_NUM_BYTES];
   logic [AES_BYTE_W-1:0]  sub_bytes_s  [AES_NUM_BYTES];
   logic [AES_BYTE_W-1:0]  lane_in_s    [LANES];
   logic [AES_BYTE_W-1:0]  lane_out_s   [LANES];

   // Split the working register into bytes and route the current group to the lanes.
   always_comb begin
      base_s = 4'(cnt_r) * LANES_4B;
      for (int k = 0; k < AES_NUM_BYTES; k++) begin
         work_bytes_s[k] = work_r[AES_BLOCK_W-1-8*k -: 8];
      end
      for (int j = 0; j < LANES; j++) begin
         lane_in_s[j] = work_bytes_s[base_s + 4'(j)];
      end
   end

   genvar g;
   generate
      for (g = 0; g < LANES; g++) begin : g_lane
         sbox u_sbox (
            .byte_val (lane_in_s[g]),
            .sub_val  (lane_out_s[g])
         );
      end
   endgenerate

   // Write the lane results back into their byte positions of the state.
   always_comb begin
      for (int k = 0; k < AES_NUM_BYTES; k++) begin
         sub_bytes_s[k] = work_bytes_s[k];
      end
      for (int j = 0; j < LANES; j++) begin
         sub_bytes_s[base_s + 4'(j)] = lane_out_s[j];
      end
      for (int k = 0; k < AES_NUM_BYTES; k++) begin
         sub_state_s[AES_BLOCK_W-1-8*k -: 8] = sub_bytes_s[k];
      end
   end

   // Next-state, counter and working-register update logic.
   always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      work_next_s  = work_r;
      case (state_r)
         ST_IDLE: begin
            if (in_valid) begin
               work_next_s  = in_data;
               cnt_next_s   = {CNT_W{1'b0}};
               state_next_s = ST_BUSY;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_BUSY: begin
            work_next_s = sub_state_s;
            if (cnt_r == CNT_LAST) begin
               state_next_s = ST_DONE;
            end else begin
               cnt_next_s   = cnt_r + CNT_ONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_DONE;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
            cnt_next_s   = {CNT_W{1'b0}};
         end
      endcase
   end

   // State, counter, working register and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         cnt_r       <= {CNT_W{1'b0}};
         work_r      <= {AES_BLOCK_W{1'b0}};
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         cnt_r       <= cnt_next_s;
         work_r      <= work_next_s;
         in_ready_r  <= (state_next_s == ST_IDLE);
         out_valid_r <= (state_next_s == ST_DONE);
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_data  = work_r;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Bench for sub_bytes_seq: three instances (LANES=1, 16, 4) checked against
// an S-box model built from GF(2^8) inversion plus the affine transform.
module tb_sub_bytes_seq;

   logic         clk = 1'b0;
   logic         rst;
   logic [2:0]   in_valid;
   logic [2:0]   out_ready;
   logic [127:0] in_data [3];

   logic         rdy_0, rdy_1, rdy_2;
   logic         vld_0, vld_1, vld_2;
   logic [127:0] dat_0, dat_1, dat_2;

   int checks   = 0;
   int failures = 0;
   logic [7:0] sbox_tbl [256];

   always #5 clk = ~clk;

   sub_bytes_seq #(.LANES(1)) u_dut_l1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[0]), .in_ready(rdy_0), .in_data(in_data[0]),
      .out_valid(vld_0), .out_ready(out_ready[0]), .out_data(dat_0));

   sub_bytes_seq #(.LANES(16)) u_dut_l16 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[1]), .in_ready(rdy_1), .in_data(in_data[1]),
      .out_valid(vld_1), .out_ready(out_ready[1]), .out_data(dat_1));

   sub_bytes_seq #(.LANES(4)) u_dut_l4 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[2]), .in_ready(rdy_2), .in_data(in_data[2]),
      .out_valid(vld_2), .out_ready(out_ready[2]), .out_data(dat_2));

   function automatic int lanes_of(input int s);
      case (s)
         0:       return 1;
         1:       return 16;
         default: return 4;
      endcase
   endfunction

   function automatic logic get_ready(input int s);
      case (s)
         0:       return rdy_0;
         1:       return rdy_1;
         default: return rdy_2;
      endcase
   endfunction

   function automatic logic get_valid(input int s);
      case (s)
         0:       return vld_0;
         1:       return vld_1;
         default: return vld_2;
      endcase
   endfunction

   function automatic logic [127:0] get_data(input int s);
      case (s)
         0:       return dat_0;
         1:       return dat_1;
         default: return dat_2;
      endcase
   endfunction

   // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
      return (v << k) | (v >> (8 - k));
   endfunction

   function automatic logic [7:0] sbox_model(input logic [7:0] a);
      logic [7:0] inv = 8'h00;
      for (int c = 1; c < 256; c++) begin
         if (gmul(a, 8'(c)) == 8'h01) inv = 8'(c);
      end
      return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
   endfunction

   function automatic logic [127:0] ref_state(input logic [127:0] d);
      logic [127:0] r;
      for (int k = 0; k < 16; k++) r[127-8*k -: 8] = sbox_tbl[d[127-8*k -: 8]];
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Push one block through instance s; hold > 0 applies that many cycles of backpressure.
   task automatic run_block(input int s, input logic [127:0] d, input logic [127:0] exp,
                            input int hold, input string tag);
      int lat = 0;
      int n   = 16 / lanes_of(s);
      out_ready[s] = (hold == 0);
      chk({tag, " idle_ready"}, 128'(get_ready(s)), 128'd1);
      in_valid[s] = 1'b1;
      in_data[s]  = d;
      tick();
      while (!get_valid(s) && lat < 40) begin
         chk({tag, " busy_ready"}, 128'(get_ready(s)), 128'd0);
         in_valid[s] = 1'($urandom_range(0, 1));
         in_data[s]  = {$urandom, $urandom, $urandom, $urandom};
         tick();
         lat++;
      end
      chk({tag, " latency"}, 128'(lat), 128'(n));
      chk({tag, " data"}, get_data(s), exp);
      for (int h = 0; h < hold; h++) begin
         in_valid[s] = 1'($urandom_range(0, 1));
         in_data[s]  = {$urandom, $urandom, $urandom, $urandom};
         tick();
         chk({tag, " hold_valid"}, 128'(get_valid(s)), 128'd1);
         chk({tag, " hold_data"}, get_data(s), exp);
         chk({tag, " hold_ready"}, 128'(get_ready(s)), 128'd0);
      end
      in_valid[s]  = 1'b0;
      out_ready[s] = 1'b1;
      tick();
      chk({tag, " valid_drop"}, 128'(get_valid(s)), 128'd0);
      chk({tag, " ready_back"}, 128'(get_ready(s)), 128'd1);
      out_ready[s] = 1'b0;
   endtask

   initial begin
      logic [127:0] q [$];
      logic [127:0] vec [2];
      logic [127:0] d;
      int cyc, outs, accepts, last_acc, v;
      logic acc;

      for (int i = 0; i < 256; i++) sbox_tbl[i] = sbox_model(8'(i));

      rst       = 1'b1;
      in_valid  = 3'b000;
      out_ready = 3'b000;
      for (int s = 0; s < 3; s++) in_data[s] = 128'h0;
      tick();
      tick();
      rst = 1'b0;
      for (int s = 0; s < 3; s++) begin
         chk("reset_ready", 128'(get_ready(s)), 128'd1);
         chk("reset_valid", 128'(get_valid(s)), 128'd0);
         chk("reset_data", get_data(s), 128'h0);
      end

      run_block(0, 128'h000102030405060708090a0b0c0d0e0f,
                128'h637c777bf26b6fc53001672bfed7ab76, 0, "l1_seq");
      run_block(0, 128'h193de3bea0f4e22b9ac68d2ae9f84808,
                128'hd42711aee0bf98f1b8b45de51e415230, 0, "l1_fips");
      run_block(1, 128'h193de3bea0f4e22b9ac68d2ae9f84808,
                128'hd42711aee0bf98f1b8b45de51e415230, 0, "l16_fips");
      run_block(0, 128'h0, {16{8'h63}}, 10, "l1_backpressure");
      run_block(2, 128'hc0c1c2c3c4c5c6c7c8c9cacbcccdcecf,
                128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 0, "l4_row_c");

      // Reset in the middle of a LANES=1 block.
      in_valid[0] = 1'b1;
      in_data[0]  = {16{8'hff}};
      tick();
      in_valid[0] = 1'b0;
      repeat (7) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_ready", 128'(rdy_0), 128'd1);
      chk("midrst_valid", 128'(vld_0), 128'd0);
      chk("midrst_data", dat_0, 128'h0);
      run_block(0, {16{8'h52}}, 128'h0, 0, "l1_after_rst");

      // Back-to-back with in_valid held high on LANES=1.
      vec[0] = {16{8'h00}};
      vec[1] = {16{8'h0f}};
      v = 0; cyc = 0; outs = 0; accepts = 0; last_acc = -1;
      out_ready[0] = 1'b1;
      in_valid[0]  = 1'b1;
      in_data[0]   = vec[0];
      while (outs < 4 && cyc < 200) begin
         acc = in_valid[0] && rdy_0;
         if (acc) begin
            q.push_back(ref_state(vec[v]));
            if (last_acc >= 0) chk("b2b_interval", 128'(cyc - last_acc), 128'd18);
            last_acc = cyc;
            accepts++;
         end
         tick();
         cyc++;
         if (acc) begin
            v = 1 - v;
            in_data[0] = vec[v];
            if (accepts == 4) in_valid[0] = 1'b0;
         end
         if (vld_0) begin
            chk("b2b_queue_nonempty", 128'(q.size() > 0), 128'd1);
            if (q.size() > 0) chk("b2b_data", dat_0, q.pop_front());
            outs++;
         end
      end
      chk("b2b_out_count", 128'(outs), 128'd4);
      chk("b2b_leftover", 128'(q.size()), 128'd0);
      in_valid[0] = 1'b0;
      tick();
      out_ready[0] = 1'b0;
      tick();

      // Random blocks with random backpressure on every instance.
      for (int s = 0; s < 3; s++) begin
         for (int k = 0; k < 4; k++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            run_block(s, d, ref_state(d), int'($urandom_range(0, 3)), "random");
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
